// File: rtl/regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_buffer
// Description : In-order write-back queue feeding the regfile32x64 write port,
//               with a youngest-match bypass lookup over pending entries.
//               Optional macro WB_ZERO_REG_EN: register 0 is hardwired zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         rf_stall,
    output logic                         rf_write,
    output logic [ADDR_W-1:0]            rf_wrAddr,
    output logic [DATA_W-1:0]            rf_wrData,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         lookup_hit,
    output logic [DATA_W-1:0]            lookup_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  data_d [DEPTH];
    logic [C_PTR_W-1:0] head_q, head_d;
    logic [C_PTR_W-1:0] tail_q, tail_d;
    logic [C_CNT_W-1:0] count_q, count_d;

    logic               w_pop;
    logic               w_push;
    logic               w_enq;
    logic [C_PTR_W-1:0] w_idx;

    always_comb begin
        empty     = (count_q == '0);
        rf_write  = !empty && !rf_stall;
        w_pop     = rf_write;
        // A full queue that is retiring this cycle frees the slot in time for a push.
        in_ready  = (count_q < C_CNT_W'(DEPTH)) || w_pop;
        w_push    = in_valid && in_ready;
`ifdef WB_ZERO_REG_EN
        w_enq     = w_push && (in_addr != '0);
`else
        w_enq     = w_push;
`endif
        rf_wrAddr = empty ? '0 : addr_q[head_q];
        rf_wrData = empty ? '0 : data_q[head_q];
        count     = count_q;

        head_d    = head_q + C_PTR_W'(w_pop);
        tail_d    = tail_q + C_PTR_W'(w_enq);
        count_d   = count_q + C_CNT_W'(w_enq) - C_CNT_W'(w_pop);
        addr_d    = addr_q;
        data_d    = data_q;
        if (w_enq) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + C_PTR_W'(i);
            if ((C_CNT_W'(i) < count_q) && (addr_q[w_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[w_idx];
            end
        end
`ifdef WB_ZERO_REG_EN
        if (lookup_addr == '0) begin
            lookup_hit  = 1'b0;
            lookup_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_buffer
// Description : Directed and randomized bench for regfile_wb_buffer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [63:0] in_data = '0;
    logic        rf_stall = 1'b0;
    logic        rf_write;
    logic [4:0]  rf_wrAddr;
    logic [63:0] rf_wrData;
    logic [4:0]  lookup_addr = '0;
    logic        lookup_hit;
    logic [63:0] lookup_data;
    logic [2:0]  count;
    logic        empty;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wb_t;

    wb_t model[$];
    int  total = 0;
    int  bad   = 0;

    regfile_wb_buffer #(.DEPTH(4), .ADDR_W(5), .DATA_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .rf_stall(rf_stall), .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit zero_drop(input logic [4:0] a);
`ifdef WB_ZERO_REG_EN
        return (a == 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: drive at posedge+1, check mid-cycle, advance the model at the edge.
    task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                        input logic st, input logic [4:0] la);
        int          n;
        logic        e_wr, e_rdy, e_hit;
        logic [4:0]  e_addr;
        logic [63:0] e_data, e_ld;
        in_valid = v; in_addr = a; in_data = d; rf_stall = st; lookup_addr = la;
        #3;
        n      = model.size();
        e_wr   = (n > 0) && !st;
        e_addr = (n > 0) ? model[0].addr : 5'd0;
        e_data = (n > 0) ? model[0].data : 64'd0;
        e_rdy  = (n < 4) || e_wr;
        e_hit  = 1'b0;
        e_ld   = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (model[i].addr == la && !zero_drop(la)) begin
                e_hit = 1'b1;
                e_ld  = model[i].data;
            end
        end
        chk("count",       64'(count),     64'(n));
        chk("empty",       64'(empty),     64'(n == 0));
        chk("rf_write",    64'(rf_write),  64'(e_wr));
        chk("rf_wrAddr",   64'(rf_wrAddr), 64'(e_addr));
        chk("rf_wrData",   rf_wrData,      e_data);
        chk("in_ready",    64'(in_ready),  64'(e_rdy));
        chk("lookup_hit",  64'(lookup_hit), 64'(e_hit));
        chk("lookup_data", lookup_data,    e_ld);
        @(posedge clk);
        if (e_wr) void'(model.pop_front());
        if (v && e_rdy && !zero_drop(a)) model.push_back('{addr: a, data: d});
        #1;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_rf_write", 64'(rf_write), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_hit",      64'(lookup_hit), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single push on empty, written next cycle
        step(1, 5'd1, {16{4'hA}}, 0, 5'd1);
        step(0, 5'd0, 64'd0,      0, 5'd1);
        step(0, 5'd0, 64'd0,      0, 5'd1);

        // Fill under stall, fifth push refused, then drain in order
        for (int i = 0; i < 5; i++)
            step(1, 5'(i + 4), 64'h1000 + 64'(i), 1, 5'd5);
        for (int i = 0; i < 5; i++)
            step(0, 5'd0, 64'd0, 0, 5'd5);

        // Same-address entries: youngest visible until both retire
        step(1, 5'd3, {16{4'hC}},  1, 5'd3);
        step(1, 5'd3, {8{8'hF0}},  1, 5'd3);
        step(0, 5'd0, 64'd0,       1, 5'd3);
        step(0, 5'd0, 64'd0,       0, 5'd3);
        step(0, 5'd0, 64'd0,       0, 5'd3);
        step(0, 5'd0, 64'd0,       0, 5'd3);

        // Full queue, no stall, continuous pushes
        for (int i = 0; i < 4; i++)
            step(1, 5'(i + 8), 64'h2000 + 64'(i), 1, 5'd9);
        for (int i = 0; i < 6; i++)
            step(1, 5'(i + 12), 64'h3000 + 64'(i), 0, 5'(i + 10));
        for (int i = 0; i < 5; i++)
            step(0, 5'd0, 64'd0, 0, 5'd0);

        // Register 0 push
        step(1, 5'd0, {64{1'b1}}, 0, 5'd0);
        step(0, 5'd0, 64'd0,      0, 5'd0);
        step(0, 5'd0, 64'd0,      0, 5'd0);

        // Asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++)
            step(1, 5'(i + 20), 64'h4000 + 64'(i), 1, 5'd21);
        rf_stall = 1'b0;
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_count",    64'(count),      64'd0);
        chk("async_empty",    64'(empty),      64'd1);
        chk("async_rf_write", 64'(rf_write),   64'd0);
        chk("async_hit",      64'(lookup_hit), 64'd0);
        @(posedge clk); #1;
        chk("rst_hold_write", 64'(rf_write),   64'd0);
        model.delete();
        reset_n = 1'b1;
        step(0, 5'd0, 64'd0, 0, 5'd21);
        step(0, 5'd0, 64'd0, 0, 5'd20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7),
                 5'($urandom_range(0, 7)),
                 {$urandom, $urandom},
                 1'($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++)
            step(0, 5'd0, 64'd0, 0, 5'($urandom_range(0, 7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
